// File: rtl/countdown_pkg.sv
// Shared types and helpers for the MM:SS BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  // A load value is legal when every digit fits its own position's range.
  function automatic logic load_is_legal(input mmss_t v, input bcd_t min_tens_max);
    return (v.min_tens <= min_tens_max) && (v.min_ones <= DIGIT_MAX) &&
           (v.sec_tens <= SEC_TENS_MAX) && (v.sec_ones <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MODULUS_MAX and raises a borrow.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int unsigned MODULUS_MAX = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic load_en,
  input  bcd_t load_value,
  input  logic dec_en,
  output bcd_t digit,
  output logic borrow_out
);

  localparam bcd_t DigitTop = bcd_t'(MODULUS_MAX);

  bcd_t digit_q, digit_d;

  // Next digit: a load overrides, otherwise count down with wrap to the top value.
  always_comb begin
    digit_d = digit_q;
    if (load_en) begin
      digit_d = load_value;
    end else if (dec_en) begin
      digit_d = (digit_q == 4'd0) ? DigitTop : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, reload register and a chain of four digits.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned AUTO_RELOAD  = 0,
  parameter int unsigned MAX_MIN_TENS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        secondTick,
  input  logic        load,
  input  logic [15:0] loadValue,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        expiredPulse,
  output logic        loadError
);

  localparam bcd_t MinTensMax = bcd_t'(MAX_MIN_TENS);

  state_t state_q, state_d;
  mmss_t  reload_q, reload_d;
  logic   pulse_q, pulse_d;
  logic   err_q, err_d;

  mmss_t  cur;
  mmss_t  dig_load_value;
  logic   dig_load;
  logic   dec;

  bcd_t   so, st, mo, mt;
  logic   borrow_so, borrow_st, borrow_mo, borrow_unused;

  logic   cur_zero, cur_one, reload_ok;

  assign cur       = '{min_tens: mt, min_ones: mo, sec_tens: st, sec_ones: so};
  assign cur_zero  = (cur == '0);
  assign cur_one   = (cur == 16'h0001);  // the only value whose decrement gives 00:00
  assign reload_ok = (AUTO_RELOAD != 0) && (reload_q != '0);

  // Request arbitration (clear > load > pause > start > tick) and next state.
  always_comb begin
    state_d        = state_q;
    reload_d       = reload_q;
    pulse_d        = 1'b0;
    err_d          = 1'b0;
    dig_load       = 1'b0;
    dig_load_value = '0;
    dec            = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      dig_load = 1'b1;
    end else if (load) begin
      // A load while running is swallowed silently.
      if (state_q != RUNNING) begin
        if (load_is_legal(mmss_t'(loadValue), MinTensMax)) begin
          dig_load       = 1'b1;
          dig_load_value = mmss_t'(loadValue);
          reload_d       = mmss_t'(loadValue);
          if (state_q == EXPIRED) state_d = IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (pause) begin
      if (state_q == RUNNING) state_d = PAUSED;
    end else if (start) begin
      unique case (state_q)
        IDLE:    state_d = cur_zero ? EXPIRED : RUNNING;
        PAUSED:  state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end else if (secondTick && (state_q == RUNNING) && !cur_zero) begin
      if (cur_one) begin
        pulse_d = 1'b1;
        if (reload_ok) begin
          dig_load       = 1'b1;
          dig_load_value = reload_q;
        end else begin
          dec     = 1'b1;
          state_d = EXPIRED;
        end
      end else begin
        dec = 1'b1;
      end
    end
  end

  // Control state, reload value and registered pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  bcd_down_digit #(.MODULUS_MAX(9)) u_sec_ones (
    .clock      (clock),
    .reset      (reset),
    .load_en    (dig_load),
    .load_value (dig_load_value.sec_ones),
    .dec_en     (dec),
    .digit      (so),
    .borrow_out (borrow_so)
  );

  bcd_down_digit #(.MODULUS_MAX(5)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .load_en    (dig_load),
    .load_value (dig_load_value.sec_tens),
    .dec_en     (borrow_so),
    .digit      (st),
    .borrow_out (borrow_st)
  );

  bcd_down_digit #(.MODULUS_MAX(9)) u_min_ones (
    .clock      (clock),
    .reset      (reset),
    .load_en    (dig_load),
    .load_value (dig_load_value.min_ones),
    .dec_en     (borrow_st),
    .digit      (mo),
    .borrow_out (borrow_mo)
  );

  // Decrement only happens on a nonzero count, so the top digit never borrows.
  bcd_down_digit #(.MODULUS_MAX(MAX_MIN_TENS)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .load_en    (dig_load),
    .load_value (dig_load_value.min_tens),
    .dec_en     (borrow_mo),
    .digit      (mt),
    .borrow_out (borrow_unused)
  );

  assign digits       = cur;
  assign running      = (state_q == RUNNING);
  assign expired      = (state_q == EXPIRED);
  assign expiredPulse = pulse_q;
  assign loadError    = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a seconds-based model.
module tb_countdown_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        secondTick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] loadValue = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] digits0, digits1;
  logic        running0, running1, expired0, expired1;
  logic        pulse0, pulse1, err0, err1;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.AUTO_RELOAD(0), .MAX_MIN_TENS(9)) dut0 (
    .clock(clock), .reset(reset), .secondTick(secondTick), .load(load),
    .loadValue(loadValue), .start(start), .pause(pause), .clear(clear),
    .digits(digits0), .running(running0), .expired(expired0),
    .expiredPulse(pulse0), .loadError(err0)
  );

  countdown_timer #(.AUTO_RELOAD(1), .MAX_MIN_TENS(9)) dut1 (
    .clock(clock), .reset(reset), .secondTick(secondTick), .load(load),
    .loadValue(loadValue), .start(start), .pause(pause), .clear(clear),
    .digits(digits1), .running(running1), .expired(expired1),
    .expiredPulse(pulse1), .loadError(err1)
  );

  always #5 clock = ~clock;

  // Reference model: the count is kept as plain seconds.
  localparam int MIdle = 0, MRun = 1, MPause = 2, MExp = 3;

  typedef struct packed {
    int          st;
    int          secs;
    logic [15:0] rel;
    logic        pulse;
    logic        err;
  } model_t;

  model_t m0, m1;

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit legal(input logic [15:0] v);
    return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
  endfunction

  function automatic model_t step(input model_t m, input bit ar, input bit c, input bit l,
                                  input logic [15:0] lv, input bit s, input bit p,
                                  input bit t);
    model_t n;
    n = m;
    n.pulse = 1'b0;
    n.err = 1'b0;
    if (c) begin
      n.st = MIdle;
      n.secs = 0;
    end else if (l) begin
      if (m.st != MRun) begin
        if (legal(lv)) begin
          n.secs = from_bcd(lv);
          n.rel = lv;
          if (m.st == MExp) n.st = MIdle;
        end else begin
          n.err = 1'b1;
        end
      end
    end else if (p) begin
      if (m.st == MRun) n.st = MPause;
    end else if (s) begin
      if (m.st == MIdle) n.st = (m.secs != 0) ? MRun : MExp;
      else if (m.st == MPause) n.st = MRun;
    end else if (t && m.st == MRun && m.secs > 0) begin
      n.secs = m.secs - 1;
      if (n.secs == 0) begin
        n.pulse = 1'b1;
        if (ar && m.rel != 16'h0000) n.secs = from_bcd(m.rel);
        else n.st = MExp;
      end
    end
    return n;
  endfunction

  function automatic logic [19:0] exp_vec(input model_t m);
    return {to_bcd(m.secs), m.st == MRun, m.st == MExp, m.pulse, m.err};
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.st = MIdle;
    m.secs = 0;
    m.rel = '0;
    m.pulse = 1'b0;
    m.err = 1'b0;
    return m;
  endfunction

  // Drive one cycle of requests from a negedge; returns at the following negedge.
  task automatic do_cycle(input bit c, input bit l, input logic [15:0] lv, input bit s,
                          input bit p, input bit t);
    clear = c; load = l; loadValue = lv; start = s; pause = p; secondTick = t;
    @(posedge clock);
    m0 = step(m0, 1'b0, c, l, lv, s, p, t);
    m1 = step(m1, 1'b1, c, l, lv, s, p, t);
    #1;
    clear = 0; load = 0; start = 0; pause = 0; secondTick = 0;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    m0 = model_reset();
    m1 = model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({digits0, running0, expired0, pulse0, err0} !== 20'h0) begin
      failures++;
      $display("FAIL reset_dut0: got %h expected 00000", {digits0, running0, expired0, pulse0, err0});
    end
    checks++;
    if ({digits1, running1, expired1, pulse1, err1} !== 20'h0) begin
      failures++;
      $display("FAIL reset_dut1: got %h expected 00000", {digits1, running1, expired1, pulse1, err1});
    end
  endtask

  task automatic test_countdown_borrow();
    logic [15:0] tbl [5];
    tbl = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100};
    do_cycle(0, 1, 16'h0105, 0, 0, 0);
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    checks++;
    if (running0 !== 1'b1) begin
      failures++;
      $display("FAIL borrow_running: got %b expected 1", running0);
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 0, 16'h0000, 0, 0, 1);
      checks++;
      if (digits0 !== tbl[i] || digits0 !== to_bcd(m0.secs)) begin
        failures++;
        $display("FAIL borrow_tick%0d: got %h expected %h", i, digits0, tbl[i]);
      end
    end
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if (digits0 !== 16'h0059) begin
      failures++;
      $display("FAIL borrow_minutes: got %h expected 0059", digits0);
    end
  endtask

  task automatic test_expiry();
    do_cycle(1, 0, 16'h0000, 0, 0, 0);
    do_cycle(0, 1, 16'h0002, 0, 0, 0);
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits0, expired0, pulse0, running0} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL expiry_edge: got d=%h exp=%b pulse=%b run=%b expected 0000 1 1 0",
               digits0, expired0, pulse0, running0);
    end
    do_cycle(0, 0, 16'h0000, 0, 0, 0);
    checks++;
    if ({pulse0, expired0} !== 2'b01) begin
      failures++;
      $display("FAIL expiry_pulse_width: got pulse=%b exp=%b expected 0 1", pulse0, expired0);
    end
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits0, pulse0} !== {16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL expiry_no_wrap: got d=%h pulse=%b expected 0000 0", digits0, pulse0);
    end
  endtask

  task automatic test_load_error();
    do_cycle(1, 0, 16'h0000, 0, 0, 0);
    do_cycle(0, 1, 16'h0042, 0, 0, 0);
    do_cycle(0, 1, 16'h0070, 0, 0, 0);
    checks++;
    if ({err0, digits0} !== {1'b1, 16'h0042}) begin
      failures++;
      $display("FAIL load_err_sectens: got err=%b d=%h expected 1 0042", err0, digits0);
    end
    do_cycle(0, 0, 16'h0000, 0, 0, 0);
    checks++;
    if (err0 !== 1'b0) begin
      failures++;
      $display("FAIL load_err_width: got %b expected 0", err0);
    end
    do_cycle(0, 1, 16'hA000, 0, 0, 0);
    checks++;
    if ({err0, digits0} !== {1'b1, 16'h0042}) begin
      failures++;
      $display("FAIL load_err_mintens: got err=%b d=%h expected 1 0042", err0, digits0);
    end
  endtask

  task automatic test_pause();
    do_cycle(1, 0, 16'h0000, 0, 0, 0);
    do_cycle(0, 1, 16'h0030, 0, 0, 0);
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    do_cycle(0, 0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits0, running0} !== {16'h0030, 1'b0}) begin
      failures++;
      $display("FAIL pause_hold: got d=%h run=%b expected 0030 0", digits0, running0);
    end
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits0, running0} !== {16'h0029, 1'b1}) begin
      failures++;
      $display("FAIL pause_resume: got d=%h run=%b expected 0029 1", digits0, running0);
    end
    do_cycle(1, 1, 16'h0555, 0, 0, 1);
    checks++;
    if ({digits0, running0, expired0, err0} !== {16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL clear_priority: got d=%h run=%b exp=%b err=%b expected 0000 0 0 0",
               digits0, running0, expired0, err0);
    end
  endtask

  task automatic test_auto_reload();
    do_cycle(1, 0, 16'h0000, 0, 0, 0);
    do_cycle(0, 1, 16'h0003, 0, 0, 0);
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits1, pulse1, running1, expired1} !== {16'h0003, 3'b110}) begin
      failures++;
      $display("FAIL auto_reload: got d=%h pulse=%b run=%b exp=%b expected 0003 1 1 0",
               digits1, pulse1, running1, expired1);
    end
    checks++;
    if ({digits0, expired0} !== {16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL no_reload_contrast: got d=%h exp=%b expected 0000 1", digits0, expired0);
    end
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits1, pulse1} !== {16'h0002, 1'b0}) begin
      failures++;
      $display("FAIL auto_reload_continue: got d=%h pulse=%b expected 0002 0", digits1, pulse1);
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1, 0, 16'h0000, 0, 0, 0);
    do_cycle(0, 1, 16'h0015, 0, 0, 0);
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if (digits0 !== 16'h0012) begin
      failures++;
      $display("FAIL async_pre: got %h expected 0012", digits0);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({digits0, running0, expired0, pulse0, err0} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset_now: got %h expected 00000",
               {digits0, running0, expired0, pulse0, err0});
    end
    m0 = model_reset();
    m1 = model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    do_cycle(0, 0, 16'h0000, 0, 0, 1);
    checks++;
    if ({digits0, running0, pulse0} !== {16'h0000, 2'b00}) begin
      failures++;
      $display("FAIL async_after: got d=%h run=%b pulse=%b expected 0000 0 0",
               digits0, running0, pulse0);
    end
    do_cycle(0, 0, 16'h0000, 1, 0, 0);
    checks++;
    if ({running0, expired0} !== 2'b01) begin
      failures++;
      $display("FAIL async_idle_zero_start: got run=%b exp=%b expected 0 1", running0, expired0);
    end
  endtask

  task automatic test_random();
    int r;
    bit c, l, s, p, t;
    logic [15:0] lv;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 3);
      l = (r >= 3 && r < 11);
      p = (r >= 11 && r < 15);
      s = (r >= 15 && r < 27);
      t = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) lv = 16'($urandom);
      else lv = {4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      do_cycle(c, l, lv, s, p, t);
      checks++;
      if ({digits0, running0, expired0, pulse0, err0} !== exp_vec(m0)) begin
        failures++;
        $display("FAIL random_dut0 cycle %0d: got %h expected %h", n,
                 {digits0, running0, expired0, pulse0, err0}, exp_vec(m0));
      end
      checks++;
      if ({digits1, running1, expired1, pulse1, err1} !== exp_vec(m1)) begin
        failures++;
        $display("FAIL random_dut1 cycle %0d: got %h expected %h", n,
                 {digits1, running1, expired1, pulse1, err1}, exp_vec(m1));
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_countdown_borrow();
    test_expiry();
    test_load_error();
    test_pause();
    test_auto_reload();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
